// File: rtl/loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : loader_pkg
//  Brief    : Shared state encoding and stream-format constants for the
//             instruction-memory loader.
//  Revision : 1.0 - initial release
// ============================================================================
package loader_pkg;

    // Length header is a little-endian word count of this many bytes
    localparam int HDR_BYTES  = 2;
    // Each instruction word arrives as this many little-endian bytes
    localparam int WORD_BYTES = 4;
    // Width of the byte-lane counter inside one word
    localparam int LANE_W     = $clog2(WORD_BYTES);

    typedef enum logic [2:0] {
        ST_LEN_LO = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_DATA   = 3'd2,
        ST_WRITE  = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERR    = 3'd5
    } state_e;

endpackage
`default_nettype wire

// File: rtl/word_assembler.sv
`default_nettype none
// ============================================================================
//  Module   : word_assembler
//  Brief    : Collects bytes into a 32-bit little-endian word. The first byte
//             of a word ends up in bits 7:0. 'last' flags that the next
//             pushed byte completes the word.
//  Revision : 1.0 - initial release
// ============================================================================
module word_assembler
    import loader_pkg::*;
(
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    clear,
    input  logic                    push,
    input  logic [7:0]              byte_in,
    output logic [8*WORD_BYTES-1:0] word,
    output logic                    last
);

    logic [LANE_W-1:0]       cnt_q, cnt_d;
    logic [8*WORD_BYTES-1:0] sr_q, sr_d;

    // Next lane count and shift value; new bytes enter at the top so that
    // after a full word the first byte has drifted down to lane 0.
    always_comb begin
        cnt_d = cnt_q;
        sr_d  = sr_q;
        if (clear) begin
            cnt_d = '0;
            sr_d  = '0;
        end else if (push) begin
            cnt_d = cnt_q + LANE_W'(1);
            sr_d  = {byte_in, sr_q[8*WORD_BYTES-1:8]};
        end
    end

    // Lane counter and assembly register, cleared by the active-low reset
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            cnt_q <= '0;
            sr_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            sr_q  <= sr_d;
        end
    end

    assign word = sr_q;
    assign last = (cnt_q == LANE_W'(WORD_BYTES - 1));

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : imem_loader
//  Brief    : Receives a length-prefixed byte stream, writes the contained
//             32-bit words into instruction memory and holds the CPU in reset
//             until the whole image has been written.
//  Revision : 1.0 - initial release
// ============================================================================
module imem_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              reload,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              err
);

    localparam int LEN_W = 8 * HDR_BYTES;
    // Largest legal word count; one wider than the header so it is exact
    localparam logic [LEN_W:0] CAPACITY = (LEN_W + 1)'(1) << ADDR_W;

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  n_q, n_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              in_ready_q, in_ready_d;
    logic              imem_we_q, imem_we_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              accept;
    logic [LEN_W-1:0]  n_full;
    logic              idx_last;
    logic              asm_clear;
    logic              asm_push;
    logic [31:0]       asm_word;
    logic              asm_last;

    assign accept   = in_valid & in_ready_q;
    assign n_full   = {in_data, n_q[7:0]};
    // Compare index+1 against N so N-1 never has to be formed (N=0 never
    // reaches DATA, and the widened sum cannot overflow at full capacity)
    assign idx_last = ((LEN_W + 1)'(idx_q) + (LEN_W + 1)'(1)) == {1'b0, n_q};

    word_assembler u_asm (
        .CLK     (CLK),
        .RESET   (RESET),
        .clear   (asm_clear),
        .push    (asm_push),
        .byte_in (in_data),
        .word    (asm_word),
        .last    (asm_last)
    );

    // Next-state logic; outputs are derived from the next state so they are
    // registered and line up with the state they describe.
    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        idx_d     = idx_q;
        asm_clear = 1'b0;
        asm_push  = 1'b0;
        case (state_q)
            ST_LEN_LO: begin
                if (accept) begin
                    n_d[7:0] = in_data;
                    state_d  = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                if (accept) begin
                    n_d = n_full;
                    if (n_full == '0) begin
                        state_d = ST_DONE;
                    end else if ({1'b0, n_full} > CAPACITY) begin
                        state_d = ST_ERR;
                    end else begin
                        idx_d     = '0;
                        asm_clear = 1'b1;
                        state_d   = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (accept) begin
                    asm_push = 1'b1;
                    if (asm_last) begin
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                if (idx_last) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + ADDR_W'(1);
                    state_d = ST_DATA;
                end
            end
            ST_DONE: begin
                if (reload) begin
                    state_d = ST_LEN_LO;
                end
            end
            ST_ERR: begin
                state_d = ST_ERR;
            end
            default: begin
                state_d = ST_LEN_LO;
            end
        endcase

        in_ready_d  = (state_d == ST_LEN_LO) || (state_d == ST_LEN_HI) ||
                      (state_d == ST_DATA);
        imem_we_d   = (state_d == ST_WRITE);
        cpu_reset_d = (state_d != ST_DONE);
        done_d      = (state_d == ST_DONE);
        err_d       = (state_d == ST_ERR);
    end

    // State, counters and registered outputs
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q     <= ST_LEN_LO;
            n_q         <= '0;
            idx_q       <= '0;
            in_ready_q  <= 1'b0;
            imem_we_q   <= 1'b0;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            idx_q       <= idx_d;
            in_ready_q  <= in_ready_d;
            imem_we_q   <= imem_we_d;
            cpu_reset_q <= cpu_reset_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign imem_we    = imem_we_q;
    assign imem_addr  = idx_q;
    assign imem_wdata = asm_word;
    assign cpu_reset  = cpu_reset_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule
`default_nettype wire

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter ADDR_W, default 8, instruction-memory word-address width; capacity is 2**ADDR_W words.
REQ-002 CLK  input  1  system clock; all state updates on the rising edge.
REQ-003 RESET  input  1  synchronous, active-low reset.
REQ-004 in_valid  input  1  upstream byte is valid.
REQ-005 in_data  input  8  upstream byte.
REQ-006 in_ready  output  1  loader can accept a byte.
REQ-007 reload  input  1  single-cycle request to start a new load from DONE.
REQ-008 imem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-009 imem_addr  output  ADDR_W  word address of the write.
REQ-010 imem_wdata  output  32  word written.
REQ-011 cpu_reset  output  1  active-high reset to the CPU top, held while loading.
REQ-012 done  output  1  image loaded, CPU released.
REQ-013 err  output  1  header word count exceeds capacity.

Function
REQ-014 A byte SHALL be accepted only on a rising CLK edge where in_valid and in_ready are both 1.
REQ-015 The stream SHALL be a 2-byte little-endian word count N, followed by 4N bytes forming N little-endian 32-bit words.
REQ-016 The states SHALL be LEN_LO, LEN_HI, DATA, WRITE, DONE and ERR.
REQ-017 LEN_LO SHALL accept a byte and go to LEN_HI; LEN_HI SHALL accept a byte and then branch on N.
REQ-018 In LEN_HI: N=0 goes to DONE with no writes; N>2**ADDR_W goes to ERR; otherwise the state goes to DATA, with the word index and byte counter cleared.
REQ-019 DATA SHALL accept bytes into lanes 0..3 (first byte in bits 7:0); on acceptance of byte 3 the state SHALL go to WRITE.
REQ-020 WRITE SHALL last exactly one cycle, with imem_we=1, imem_addr=word index and imem_wdata=assembled word.
REQ-021 Latency: if byte 3 is accepted at edge t, imem_we SHALL be 1 in the cycle after t, and in_ready SHALL be 1 again one cycle later.
REQ-022 WRITE SHALL go to DONE if the word index equals N-1; otherwise it SHALL increment the index and return to DATA.
REQ-023 in_ready SHALL be 1 in LEN_LO, LEN_HI and DATA, and 0 in WRITE, DONE and ERR.
REQ-024 cpu_reset SHALL be 1 in every state except DONE, and 0 in DONE.
REQ-025 done SHALL be 1 only in DONE; err SHALL be 1 only in ERR.
REQ-026 imem_we SHALL be 0 outside WRITE.
REQ-027 In DONE, reload=1 SHALL go to LEN_LO; cpu_reset SHALL return to 1 on the same edge, and done SHALL drop.
REQ-028 reload SHALL be ignored in all states other than DONE.
REQ-029 ERR SHALL be left only by RESET.
REQ-030 N=2**ADDR_W SHALL be legal; the last write goes to address 2**ADDR_W-1, and the index SHALL not wrap before DONE.
REQ-031 A partial word is held indefinitely while in_valid=0; no timeout.

Reset
REQ-032 When RESET=0 at a rising edge, the loader SHALL enter LEN_LO.
REQ-033 Reset values: in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_reset=1, done=0, err=0; N, index, byte counter and assembly register cleared.
REQ-034 in_ready SHALL become 1 in the first cycle after RESET returns to 1.
REQ-035 Reset mid-load SHALL discard the partial word and issue no further writes.

Structure
REQ-036 Package loader_pkg SHALL hold the state encoding and the constants HDR_BYTES=2 and WORD_BYTES=4.
REQ-037 Byte-lane assembly (byte counter plus 32-bit shift register) SHALL be sub-module word_assembler; the FSM, counters and outputs live in imem_loader.

Verification
REQ-038 Stream 02 00 | 13 00 00 00 | 93 00 10 00 with in_valid held 1 -> writes addr0=0x00000013 and addr1=0x00100093, then done=1 and cpu_reset=0.
REQ-039 Stream 00 00 -> DONE with no imem_we pulse; cpu_reset falls 1 cycle after the second byte is accepted.
REQ-040 With ADDR_W=8, stream 01 01 (N=257) -> err=1, in_ready=0, cpu_reset=1, and no writes until RESET.
REQ-041 Random in_valid gaps during a 3-word load -> same 3 words/addresses as gapless; in_ready=0 exactly in each WRITE cycle.
REQ-042 RESET=0 after 2 data bytes of word 0, then a fresh stream 01 00 | EF BE AD DE -> single write addr0=0xDEADBEEF.
REQ-043 In DONE, pulse reload, then stream 01 00 | 01 00 00 00 -> cpu_reset=1 during the reload, addr0 rewritten to 0x00000001, then done=1.
